// File: rtl/dispense_pkg.sv
// Shared types and defaults for the drink dispense sequencer:
// step encoding (also used by the menu FSM), error codes, timing defaults.
package dispense_pkg;

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_CHECK   = 4'd1,
      S_HEAT    = 4'd2,
      S_GRIND   = 4'd3,
      S_BREW    = 4'd4,
      S_CREAMER = 4'd5,
      S_CHOC    = 4'd6,
      S_SETTLE  = 4'd7,
      S_DONE    = 4'd8,
      S_ABORT   = 4'd9
   } state_t;

   localparam logic [2:0] ERR_NONE    = 3'd0;
   localparam logic [2:0] ERR_CONS    = 3'd1;
   localparam logic [2:0] ERR_CANCEL  = 3'd2;
   localparam logic [2:0] ERR_FAULT   = 3'd3;
   localparam logic [2:0] ERR_TIMEOUT = 3'd4;

   localparam int unsigned DEF_TICK_DIV   = 50_000;
   localparam int unsigned DEF_SETTLE_MS  = 500;
   localparam int unsigned DEF_TIMEOUT_MS = 30_000;

   // A zero-length step ends on its first cycle.
   function automatic logic span_done(input logic [15:0] dur,
                                      input logic [15:0] ms,
                                      input logic        tick);
      return (dur == 16'd0) || (tick && (ms == dur - 16'd1));
   endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every TICK_DIV cycles.
// clear restarts the count this cycle; hold freezes it.
import dispense_pkg::*;

module ms_tick_gen #(
   parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic hold,
   output logic tick
);

   localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

   logic [15:0] cnt;
   logic [15:0] cur;

   assign cur  = clear ? 16'd0 : cnt;
   assign tick = !hold && (cur == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       cnt <= 16'd0;
      else if (hold) cnt <= cur;
      else if (tick) cnt <= 16'd0;
      else           cnt <= cur + 16'd1;
   end

endmodule

// File: rtl/dispense_sequencer.sv
// Drink dispense sequencer: heat, grind, brew, creamer, chocolate, settle.
// DISPENSE_WATCHDOG_EN adds a timeout on HEAT and BREW pressure stalls.
import dispense_pkg::*;

module dispense_sequencer #(
   parameter int unsigned TICK_DIV   = DEF_TICK_DIV,
   parameter int unsigned SETTLE_MS  = DEF_SETTLE_MS,
   parameter int unsigned TIMEOUT_MS = DEF_TIMEOUT_MS
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        cancel,
   input  logic        fault,
   input  logic [15:0] grind_ms,
   input  logic [15:0] water_ms,
   input  logic [11:0] creamer_ms,
   input  logic [11:0] choc_ms,
   input  logic        paper_ok,
   input  logic        bin_ok,
   input  logic        creamer_ok,
   input  logic        choc_ok,
   input  logic        temp_ready,
   input  logic        pressure_ready,
   output logic        heater_en,
   output logic        grinder_en,
   output logic        pump_en,
   output logic        creamer_vlv,
   output logic        choc_vlv,
   output logic        busy,
   output logic        done,
   output logic        aborted,
   output logic [2:0]  err_code,
   output logic [3:0]  step
);

   localparam logic [15:0] SETTLE = 16'(SETTLE_MS);

   state_t      state, nxt;
   logic [2:0]  nerr;
   logic [15:0] ms, g_ms, w_ms;
   logic [11:0] c_ms, h_ms;
   logic        entry, tick, hold, timeout;
   logic        accept, abortable, cons_bad;

   assign step      = state;
   assign hold      = (state == S_BREW) && !pressure_ready;
   assign accept    = (state == S_IDLE) && start && !cancel;
   assign abortable = (state != S_IDLE) && (state != S_DONE) &&
                      (state != S_ABORT);
   assign cons_bad  = !paper_ok || !bin_ok ||
                      ((c_ms != 12'd0) && !creamer_ok) ||
                      ((h_ms != 12'd0) && !choc_ok);

   ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk(clk), .rst(rst), .clear(entry), .hold(hold), .tick(tick)
   );

`ifdef DISPENSE_WATCHDOG_EN
   // Separate prescaler so only waiting time is counted.
   logic        waiting, wtick;
   logic [15:0] wms;

   assign waiting = (state == S_HEAT) || hold;
   assign timeout = wtick && (wms == 16'(TIMEOUT_MS - 1));

   ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_wdog_div (
      .clk(clk), .rst(rst), .clear(entry), .hold(!waiting), .tick(wtick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                wms <= 16'd0;
      else if (nxt != state)  wms <= 16'd0;
      else if (wtick)         wms <= wms + 16'd1;
   end
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^16'(TIMEOUT_MS);
   assign timeout = 1'b0;
`endif

   always_comb begin
      nxt  = state;
      nerr = err_code;
      case (state)
         S_IDLE: if (accept) begin
            nxt  = fault ? S_ABORT : S_CHECK;
            nerr = fault ? ERR_FAULT : ERR_NONE;
         end
         S_CHECK: begin
            nxt = cons_bad ? S_ABORT : S_HEAT;
            if (cons_bad) nerr = ERR_CONS;
         end
         S_HEAT:    if (temp_ready) nxt = S_GRIND;
         S_GRIND:   if (span_done(g_ms, ms, tick)) nxt = S_BREW;
         S_BREW:    if (span_done(w_ms, ms, tick)) nxt = S_CREAMER;
         S_CREAMER: if (span_done({4'd0, c_ms}, ms, tick)) nxt = S_CHOC;
         S_CHOC:    if (span_done({4'd0, h_ms}, ms, tick)) nxt = S_SETTLE;
         S_SETTLE:  if (span_done(SETTLE, ms, tick)) nxt = S_DONE;
         default:   nxt = S_IDLE;
      endcase
      if (abortable) begin
         if (fault) begin
            nxt = S_ABORT; nerr = ERR_FAULT;
         end else if (cancel) begin
            nxt = S_ABORT; nerr = ERR_CANCEL;
         end else if (timeout) begin
            nxt = S_ABORT; nerr = ERR_TIMEOUT;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         entry       <= 1'b0;
         ms          <= 16'd0;
         g_ms        <= 16'd0;
         w_ms        <= 16'd0;
         c_ms        <= 12'd0;
         h_ms        <= 12'd0;
         err_code    <= ERR_NONE;
         heater_en   <= 1'b0;
         grinder_en  <= 1'b0;
         pump_en     <= 1'b0;
         creamer_vlv <= 1'b0;
         choc_vlv    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         aborted     <= 1'b0;
      end else begin
         state    <= nxt;
         entry    <= (nxt != state);
         ms       <= (nxt != state) ? 16'd0 : ms + {15'd0, tick};
         err_code <= nerr;
         if (accept) begin
            g_ms <= grind_ms;
            w_ms <= water_ms;
            c_ms <= creamer_ms;
            h_ms <= choc_ms;
         end
         // Outputs follow the state being entered so they line up with step.
         heater_en   <= (nxt == S_HEAT) || (nxt == S_BREW);
         grinder_en  <= (nxt == S_GRIND) && (g_ms != 16'd0);
         pump_en     <= (nxt == S_BREW) && (w_ms != 16'd0) && pressure_ready;
         creamer_vlv <= (nxt == S_CREAMER) && (c_ms != 12'd0);
         choc_vlv    <= (nxt == S_CHOC) && (h_ms != 12'd0);
         busy        <= (nxt != S_IDLE);
         done        <= (nxt == S_DONE);
         aborted     <= (nxt == S_ABORT);
      end
   end

endmodule
